core_bus_requester: RTL
=======================

# core_bus_requester

Core-side bus initiator for the dual-core snooping system: the requesting end of the req/grant bus protocol that the bus controller arbitrates. It takes one L1 miss or upgrade from its core's pipeline, requests the shared bus, and stalls the core for the whole transaction. Once granted, it drives a one-cycle bus command toward the peer core and L2, then returns the response data and sharing status to the L1. One instance sits between each Processor's L1 controller and the bus controller.

## Interface
- TIMEOUT_CYCLES, 64: maximum number of WAIT cycles before the transaction is aborted (≥2).
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- miss_valid  in  1  L1 requests a bus transaction; sampled only in IDLE.
- miss_op  in  2  bus operation: 01 BusRd, 10 BusRdX, 11 BusUpgr. 00 is ignored.
- miss_address  in  32  block address.
- store_data  in  32  store word; forwarded only for opcode 7'b0100011.
- opcode_in  in  7  opcode of the instruction that missed.
- grant  in  1  bus ownership from the bus controller.
- bus_resp_valid  in  1  response strobe from the bus controller.
- bus_data_in  in  32  response data, qualified by bus_resp_valid.
- cache_hit_in  in  1  peer snoop hit, qualified by bus_resp_valid.
- req_core  out  1  bus request.
- bus_operation_out  out  2  bus command; 00 when not in ADDR.
- bus_address_out  out  32  latched address.
- data_to_L2  out  32  latched store data in ADDR for stores, else 0.
- opcode_out  out  7  latched opcode, valid in ADDR, else 0.
- stall_out  out  1  core stall.
- flush_out  out  1  one-cycle end-of-transaction pulse that releases the arbiter.
- fill_valid  out  1  one-cycle response to the L1.
- fill_data  out  32  captured response data.
- fill_shared  out  1  peer held the line; the L1 installs it Shared rather than Exclusive.
- bus_error  out  1  one-cycle timeout pulse, coincident with fill_valid.

## Operation
- States: IDLE, REQ, ADDR, WAIT, DONE.
- IDLE:
  - miss_valid=1 with miss_op≠00 latches op, address, store_data and opcode_in, then → REQ.
  - miss_op=00 is dropped.
- REQ: req_core=1. grant=1 → ADDR. Otherwise hold indefinitely; there is no timeout in REQ.
- ADDR:
  - Exactly one cycle; req_core=1.
  - Drives bus_operation_out, bus_address_out and opcode_out.
  - Drives data_to_L2 = latched store data when the opcode is 7'b0100011, else 0.
  - → WAIT.
- WAIT:
  - req_core=1; bus_operation_out=00; the timeout counter clears on WAIT entry.
  - bus_resp_valid=1 captures fill_data=bus_data_in and fill_shared=cache_hit_in, then → DONE.
  - BusUpgr also waits for bus_resp_valid, which acts as the acknowledge; its data is captured but meaningless.
  - Counter reaching TIMEOUT_CYCLES with no response: fill_data=0, fill_shared=0, error flag set, → DONE.
- DONE: req_core=0; fill_valid=1; flush_out=1; bus_error = error flag; → IDLE. fill_data and fill_shared hold until the next capture.
- stall_out = (state≠IDLE) OR (state==IDLE AND miss_valid AND miss_op≠00). It is combinational and deasserts in the cycle after DONE.
- Ignored inputs:
  - grant outside REQ.
  - bus_resp_valid outside WAIT, including in the ADDR cycle.
  - miss_valid outside IDLE.
  - A grant drop during WAIT.
- Counter width is $clog2(TIMEOUT_CYCLES+1). It saturates and cannot wrap.

## Timing
- Reset (reset=0, asynchronous):
  - State returns to IDLE from any state, including mid-transaction; no flush_out pulse is issued.
  - All outputs are 0 and all latches are cleared.
  - Operation resumes on the first rising edge after reset=1.
- Minimum latency, miss_valid to fill_valid, with grant and response both immediate: miss cycle t0 → REQ t1 → ADDR t2 → WAIT t3 (response) → DONE t4. That is 4 cycles.
- A new miss_valid in the cycle after DONE is accepted. Back-to-back transactions therefore need 5 cycles each.

## Test plan
- BusRd, addr 0x0000_0040, grant held 1, resp at first WAIT cycle with data 0xDEAD_BEEF, cache_hit_in=0 -> bus_operation_out=01 only at t2; fill_valid and flush_out at t4; fill_data=0xDEAD_BEEF; fill_shared=0; stall_out high t0–t4.
- Store BusRdX, opcode 0100011, store_data 0x1234_5678, grant delayed 3 cycles -> req_core high from t1; ADDR at t5 with data_to_L2=0x1234_5678 and opcode_out=0100011; data_to_L2=0 in every other cycle.
- BusUpgr, resp with cache_hit_in=1 -> fill_shared=1, bus_error=0.
- No response, TIMEOUT_CYCLES=4 -> bus_error=1, fill_valid=1 and fill_data=0 after 4 WAIT cycles, then IDLE.
- Reset=0 asserted in WAIT -> all outputs 0 immediately; after release a new BusRd completes normally; no spurious fill_valid.
- miss_valid pulsed in WAIT, plus bus_resp_valid in the ADDR cycle -> both ignored; exactly one fill, from the later response.

Source files
------------

// File: rtl/core_bus_requester_if.sv
// Bus-side signals between a core's bus requester and the bus controller.
interface core_bus_requester_if;
    logic        req_core;
    logic        grant;
    logic [1:0]  bus_operation_out;
    logic [31:0] bus_address_out;
    logic [31:0] data_to_L2;
    logic [6:0]  opcode_out;
    logic        flush_out;
    logic        bus_error;
    logic        bus_resp_valid;
    logic [31:0] bus_data_in;
    logic        cache_hit_in;

    modport master (
        output req_core, bus_operation_out, bus_address_out, data_to_L2,
               opcode_out, flush_out, bus_error,
        input  grant, bus_resp_valid, bus_data_in, cache_hit_in
    );

    modport slave (
        input  req_core, bus_operation_out, bus_address_out, data_to_L2,
               opcode_out, flush_out, bus_error,
        output grant, bus_resp_valid, bus_data_in, cache_hit_in
    );
endinterface

// File: rtl/core_bus_requester.sv
// Purpose: core-side bus initiator; turns one L1 miss/upgrade into a req/grant bus transaction.
// Latency: 4 cycles miss_valid to fill_valid with immediate grant and response; 5 cycles per back-to-back transaction.
// Backpressure: stall_out holds the core for the whole transaction; REQ waits on grant forever, WAIT times out.
module core_bus_requester #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    core_bus_requester_if.master bus,
    input  logic                 miss_valid,
    input  logic [1:0]           miss_op,
    input  logic [31:0]          miss_address,
    input  logic [31:0]          store_data,
    input  logic [6:0]           opcode_in,
    output logic                 stall_out,
    output logic                 fill_valid,
    output logic [31:0]          fill_data,
    output logic                 fill_shared
);
    typedef enum logic [2:0] {IDLE, REQ, ADDR, WAIT, DONE} state_t;

    localparam int        CW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);
    localparam logic [6:0] STORE_OPC = 7'b0100011;

    state_t      state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [1:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] store_q;
    logic [6:0]  opc_q;

    logic        req_q;
    logic [1:0]  bus_op_q;
    logic [31:0] l2_dat_q;
    logic [6:0]  opc_out_q;
    logic        flush_q;
    logic        err_q;

    // Saturating so a stuck counter can never wrap back below the limit.
    assign cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            op_q        <= '0;
            addr_q      <= '0;
            store_q     <= '0;
            opc_q       <= '0;
            req_q       <= 1'b0;
            bus_op_q    <= '0;
            l2_dat_q    <= '0;
            opc_out_q   <= '0;
            flush_q     <= 1'b0;
            err_q       <= 1'b0;
            fill_valid  <= 1'b0;
            fill_data   <= '0;
            fill_shared <= 1'b0;
        end else begin
            bus_op_q   <= '0;
            l2_dat_q   <= '0;
            opc_out_q  <= '0;
            flush_q    <= 1'b0;
            err_q      <= 1'b0;
            fill_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (miss_valid && miss_op != 2'b00) begin
                        op_q    <= miss_op;
                        addr_q  <= miss_address;
                        store_q <= (opcode_in == STORE_OPC) ? store_data : '0;
                        opc_q   <= opcode_in;
                        req_q   <= 1'b1;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    if (bus.grant) begin
                        bus_op_q  <= op_q;
                        opc_out_q <= opc_q;
                        l2_dat_q  <= (opc_q == STORE_OPC) ? store_q : '0;
                        state     <= ADDR;
                    end
                end
                ADDR: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // A response in the final counted cycle still wins over the timeout.
                    if (bus.bus_resp_valid) begin
                        fill_data   <= bus.bus_data_in;
                        fill_shared <= bus.cache_hit_in;
                        fill_valid  <= 1'b1;
                        flush_q     <= 1'b1;
                        req_q       <= 1'b0;
                        state       <= DONE;
                    end else if (cnt_nxt == CNT_MAX) begin
                        fill_data   <= '0;
                        fill_shared <= 1'b0;
                        fill_valid  <= 1'b1;
                        flush_q     <= 1'b1;
                        err_q       <= 1'b1;
                        req_q       <= 1'b0;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt_nxt;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    req_q <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign stall_out = reset &&
                       ((state != IDLE) || (miss_valid && miss_op != 2'b00));

    assign bus.req_core          = req_q;
    assign bus.bus_operation_out = bus_op_q;
    assign bus.bus_address_out   = addr_q;
    assign bus.data_to_L2        = l2_dat_q;
    assign bus.opcode_out        = opc_out_q;
    assign bus.flush_out         = flush_q;
    assign bus.bus_error         = err_q;
endmodule
